// File: rtl/axis_gen_ctrl_pkg.sv
// Shared definitions for the axis_data_generator burst controller.
// Optional watchdog is enabled by defining AXIS_GEN_WDOG_EN.
package axis_gen_ctrl_pkg;

  localparam int unsigned DefBurstSize     = 99;
  localparam int unsigned DefBurstCntW     = 16;
  localparam int unsigned DefGapW          = 16;
  localparam int unsigned DefTimeoutCycles = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StGap,
    StDone
  } ctrl_state_e;

endpackage

// File: rtl/axis_beat_monitor.sv
// Beat counter and burst-length checker for the tapped AXIS handshake.
// With AXIS_GEN_WDOG_EN defined it also counts stall cycles and pulses stall_o on timeout.
module axis_beat_monitor
  import axis_gen_ctrl_pkg::*;
#(
  parameter int unsigned BURST_SIZE = DefBurstSize
`ifdef AXIS_GEN_WDOG_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
`endif
) (
  input  logic clk_i,
  input  logic a_rst_i,
  input  logic active_i,
  input  logic clear_i,
  input  logic tvalid_i,
  input  logic tready_i,
  input  logic tlast_i,
  output logic last_o,
  output logic len_err_o,
  output logic stall_o
);

  // One spare code so an over-long burst saturates instead of wrapping onto BURST_SIZE.
  localparam int unsigned CntW = $clog2(BURST_SIZE + 2);

  logic            beat;
  logic [CntW-1:0] beat_cnt_q;

  assign beat      = active_i && tvalid_i && tready_i;
  assign last_o    = beat && tlast_i;
  assign len_err_o = last_o && (beat_cnt_q != CntW'(BURST_SIZE));

  // Index of the next beat within the current burst.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      beat_cnt_q <= '0;
    end else if (clear_i || last_o) begin
      beat_cnt_q <= '0;
    end else if (beat && !(&beat_cnt_q)) begin
      beat_cnt_q <= beat_cnt_q + CntW'(1);
    end
  end

`ifdef AXIS_GEN_WDOG_EN
  localparam int unsigned StallW = $clog2(TIMEOUT_CYCLES + 1);

  logic [StallW-1:0] stall_q;

  // Pulse on the stall cycle that brings the count to TIMEOUT_CYCLES.
  assign stall_o = active_i && !beat && (stall_q == StallW'(TIMEOUT_CYCLES - 1));

  // Consecutive RUN cycles without a beat.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      stall_q <= '0;
    end else if (!active_i || beat) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + StallW'(1);
    end
  end
`else
  assign stall_o = 1'b0;
`endif

endmodule

// File: rtl/axis_gen_burst_ctrl.sv
// Burst sequencer for axis_data_generator: gates enable per burst, inserts gaps,
// stops on burst count or abort, and flags bad burst lengths.
// Define AXIS_GEN_WDOG_EN to add the stall watchdog driving timeout_o.
module axis_gen_burst_ctrl
  import axis_gen_ctrl_pkg::*;
#(
  parameter int unsigned BURST_SIZE  = DefBurstSize,
  parameter int unsigned BURST_CNT_W = DefBurstCntW,
  parameter int unsigned GAP_W       = DefGapW
`ifdef AXIS_GEN_WDOG_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
`endif
) (
  input  logic                   clk_i,
  input  logic                   a_rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [BURST_CNT_W-1:0] num_bursts_i,
  input  logic [GAP_W-1:0]       gap_cycles_i,
  output logic                   gen_enable_o,
  input  logic                   mon_tvalid_i,
  input  logic                   mon_tready_i,
  input  logic                   mon_tlast_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [BURST_CNT_W-1:0] bursts_done_o,
  output logic                   len_err_o,
  output logic                   timeout_o
);

  ctrl_state_e            state_q;
  logic [BURST_CNT_W-1:0] num_q, bursts_q, bursts_inc;
  logic [GAP_W-1:0]       gap_q, gap_cnt_q;
  logic                   abort_pend_q, enable_q, busy_q, done_q, len_err_q;
  logic                   mon_active, mon_clear, mon_last, mon_len_err, mon_stall;

  assign mon_active = (state_q == StRun);
  assign mon_clear  = (state_q == StIdle) && start_i;
  assign bursts_inc = (&bursts_q) ? bursts_q : bursts_q + BURST_CNT_W'(1);

  axis_beat_monitor #(
    .BURST_SIZE    (BURST_SIZE)
`ifdef AXIS_GEN_WDOG_EN
    ,
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
  ) u_mon (
    .clk_i    (clk_i),
    .a_rst_i  (a_rst_i),
    .active_i (mon_active),
    .clear_i  (mon_clear),
    .tvalid_i (mon_tvalid_i),
    .tready_i (mon_tready_i),
    .tlast_i  (mon_tlast_i),
    .last_o   (mon_last),
    .len_err_o(mon_len_err),
    .stall_o  (mon_stall)
  );

  // Sequencer FSM; every output is registered alongside the state transition.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      state_q      <= StIdle;
      num_q        <= '0;
      bursts_q     <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      abort_pend_q <= 1'b0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q      <= StRun;
            num_q        <= num_bursts_i;
            gap_q        <= gap_cycles_i;
            bursts_q     <= '0;
            len_err_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            enable_q     <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        StRun: begin
          if (mon_len_err) len_err_q <= 1'b1;
          if (mon_last) begin
            bursts_q <= bursts_inc;
            if (abort_pend_q || abort_i || ((num_q != '0) && (bursts_inc == num_q))) begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              enable_q <= 1'b0;
            end else if (gap_q != '0) begin
              state_q   <= StGap;
              gap_cnt_q <= gap_q - GAP_W'(1);
              enable_q  <= 1'b0;
            end
          end else if (mon_stall) begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            enable_q <= 1'b0;
          end else if (abort_i) begin
            abort_pend_q <= 1'b1;
          end
        end
        StGap: begin
          if (abort_i) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (gap_cnt_q == '0) begin
            state_q  <= StRun;
            enable_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef AXIS_GEN_WDOG_EN
  logic timeout_q;

  // Sticky watchdog flag, cleared only by a new start.
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      timeout_q <= 1'b0;
    end else if (mon_clear) begin
      timeout_q <= 1'b0;
    end else if (mon_stall) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign gen_enable_o  = enable_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign bursts_done_o = bursts_q;
  assign len_err_o     = len_err_q;

endmodule
